out_display: RTL and testbench
==============================

# out_display

Output-display stage for the 8-bit CPU: captures the byte the CPU writes to its OUT register, converts it to decimal and drives a 4-digit multiplexed 7-segment display. It sits directly downstream of the `cpu` core, consuming `display_data` together with the control word's OUT-load strobe. Binary-to-BCD conversion is sequential (shift-and-add-3), and digit scanning is counter-driven.

## Interface
Parameters:
- `SCAN_DIV`, default 4: clock cycles each digit stays enabled; legal range 1..65535.

Ports:
- `clk`  in  1  system clock, all logic on the rising edge
- `clr_n`  in  1  reset, synchronous, active-low
- `out_load`  in  1  OUT-register load strobe from the control word; one-cycle pulse
- `out_data`  in  8  byte to display (the CPU's `display_data`)
- `busy`  out  1  conversion in progress
- `an`  out  4  digit enable, one-hot, active-high; bit 0 is the ones digit
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-high

## Operation
- States: IDLE, CONV. On reset, state is IDLE.
- IDLE, `out_load`=1: capture `out_data`, clear BCD accumulator, clear shift count, go to CONV.
- CONV: each cycle, add 3 to every BCD nibble that is ≥5, then shift {bcd, bin} left by 1.
  - After the 8th shift, write hundreds/tens/ones to the digit registers and return to IDLE.
- `out_load` during CONV restarts the conversion with the new byte; the latest load wins and the old result is discarded.
- Scan:
  - A divider counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - `an`=1<<index.
  - `seg` is the decoded digit.
- Leading-zero blanking:
  - Hundreds are blank if 0.
  - Tens are blank if hundreds=0 and tens=0.
  - Ones are always shown.
  - Digit 3 is blank except for the sign (see Configuration).
- Encodings: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, minus=40, blank=00.
- Reset values: `busy`=0, `an`=4'b0001, `seg`=7'h3F, digit registers=0, sign=0, divider=0, index=0. The display therefore reads "0".

## Timing
- Load sampled at edge N: `busy`=1 from N+1 through N+8 (8 cycles). Digit registers update at edge N+8, and `busy`=0 after N+8.
- Reload at edge N+k during CONV: `busy` stays high; new result at N+k+8.
- `an` and `seg` are registered together, so they never disagree within a cycle.
- `seg` is resampled from the digit registers only at scan advance. A new value appears on each digit at that digit's next enable.
- SCAN_DIV=1: index advances every cycle.
- `clr_n` low in any state, including mid-CONV: the next edge forces reset values and the in-flight conversion is dropped.
- `clr_n` has priority over `out_load`.

## Configuration
- `SIGNED_DISPLAY_EN` defined:
  - `out_data` is two's complement. Magnitude = negative ? −x : x (9-bit safe, so 0x80→128), and the sign bit is latched with the byte.
  - Digit 3 shows minus (40) when negative, blank otherwise.
  - −0 does not exist.
- Undefined: `out_data` is unsigned 0..255, and digit 3 is always blank (still scanned).

## Structure
- Package `out_display_pkg`:
  - state enum
  - SEG_* encoding constants (digits, MINUS, BLANK)
  - 2-bit digit-index type
  - BCD digit type
- One sub-module, `seg7_decode`: combinational {blank, minus, bcd[3:0]} → seg[6:0]. It is instantiated once on the scan-selected digit.

## Test plan
All scenarios use SCAN_DIV=2.
- Reset: hold `clr_n`=0 for 2 cycles → `busy`=0, `an`=0001, `seg`=3F, scan cycles 0001→0010→0100→1000 every 2 clocks. Digits 1–3 show seg=00.
- Load 0xFF (unsigned build) → `busy` high exactly 8 cycles. The full scan then shows ones=6D, tens=6D, hundreds=5B, digit3=00 (255).
- Load 0x07 → ones=07, tens=00, hundreds=00 (blanked). Load 0x64 → hundreds=06, tens=3F, ones=3F (100, inner zero shown).
- Load 0x10, then load 0x2A three cycles later → `busy` stays high continuously until 8 cycles after the second load. Display reads 42 (tens=66, ones=5B); 16 never appears.
- `SIGNED_DISPLAY_EN`: load 0xF6 → digit3=40, tens=06, ones=3F (−10). Load 0x80 → −128 (40, 06, 5B, 7F). Load 0x7F → 127 with digit3=00.
- Drive `clr_n`=0 on the 4th CONV cycle of a 0xC8 load → next edge `busy`=0 and display reads 0. A subsequent load of 0x05 converts normally to 5.

Source files
------------

// File: rtl/out_display_pkg.sv
// Shared types and constants for the out_display stage: FSM states, digit
// index and BCD digit types, and the active-high 7-segment encodings.
package out_display_pkg;

    // Conversion controller states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_e;

    // Scan position: 0 = ones, 1 = tens, 2 = hundreds, 3 = sign
    typedef logic [1:0] digit_idx_t;

    // One decimal digit in BCD
    typedef logic [3:0] bcd_digit_t;

    // Double-dabble runs one shift per input bit
    localparam int unsigned    CONV_STEPS = 8;
    localparam int unsigned    STEP_W     = 3;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CONV_STEPS - 1);

    // Segment encodings, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Shift-and-add-3 correction applied to each BCD nibble before a shift
    function automatic bcd_digit_t add3(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder. Minus takes precedence over blank, and
// blank takes precedence over the BCD value; non-decimal codes render blank.
module seg7_decode
    import out_display_pkg::*;
(
    input  logic       blank_i,
    input  logic       minus_i,
    input  bcd_digit_t bcd_i,
    output logic [6:0] seg_o
);

    // Map the selected digit to its segment pattern
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the block leaves it unassigned and infers a latch.
        seg_o = SEG_BLANK;
        if (minus_i) begin
            seg_o = SEG_MINUS;
        end else if (!blank_i) begin
            unique case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/out_display.sv
// Output-display stage: captures the CPU OUT byte, converts it to decimal
// with a sequential shift-and-add-3 engine, and scans a 4-digit
// multiplexed 7-segment display with leading-zero blanking.
// Optional feature macro: SIGNED_DISPLAY_EN (treat the byte as two's
// complement and show a minus sign on digit 3).
module out_display
    import out_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       out_load,
    input  logic [7:0] out_data,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [7:0]        bin_q, bin_d;
    logic [11:0]       bcd_q, bcd_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              sign_conv_q, sign_conv_d;

    // Displayed result, updated only when a conversion completes
    bcd_digit_t        hund_q, hund_d;
    bcd_digit_t        tens_q, tens_d;
    bcd_digit_t        ones_q, ones_d;
    logic              sign_q, sign_d;

    // Byte as presented to the converter: magnitude plus sign flag
    logic [7:0]        load_mag;
    logic              load_neg;

`ifdef SIGNED_DISPLAY_EN
    // Two's complement magnitude; 0x80 wraps to 0x80, which reads as 128
    assign load_neg = out_data[7];
    assign load_mag = load_neg ? 8'(~out_data + 8'd1) : out_data;
`else
    assign load_neg = 1'b0;
    assign load_mag = out_data;
`endif

    // One double-dabble step: correct every nibble, then shift {bcd, bin}
    logic [11:0] bcd_adj;
    logic [19:0] shifted;

    assign bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    assign shifted = {bcd_adj, bin_q} << 1;

    // Next-state logic for the converter FSM and its datapath
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        step_d      = step_q;
        sign_conv_d = sign_conv_q;
        hund_d      = hund_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        sign_d      = sign_q;

        if (out_load) begin
            // A load in either state (re)starts conversion with the new byte
            state_d     = ST_CONV;
            bin_d       = load_mag;
            bcd_d       = '0;
            step_d      = '0;
            sign_conv_d = load_neg;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CONV: begin
                    bcd_d  = shifted[19:8];
                    bin_d  = shifted[7:0];
                    step_d = step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        hund_d  = shifted[19:16];
                        tens_d  = shifted[15:12];
                        ones_d  = shifted[11:8];
                        sign_d  = sign_conv_q;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Converter registers; clear drops any in-flight conversion
    always_ff @(posedge clk) begin
        // NOTE: clocked state is updated with non-blocking assignments so all
        // registers sample their inputs from the same pre-edge values.
        if (!clr_n) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            step_q      <= '0;
            sign_conv_q <= 1'b0;
            hund_q      <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            step_q      <= step_d;
            sign_conv_q <= sign_conv_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            sign_q      <= sign_d;
        end
    end

    assign busy = (state_q == ST_CONV);

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [15:0] div_q, div_d;
    digit_idx_t  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        div_wrap;

    // Fields handed to the decoder for the digit about to be enabled
    bcd_digit_t  sel_bcd;
    logic        sel_blank;
    logic        sel_minus;
    logic [6:0]  dec_seg;

    assign div_wrap = (div_q == DIV_LAST);

    // Divider, index advance and selection of the next digit to show
    always_comb begin
        div_d     = div_wrap ? '0 : div_q + 16'd1;
        idx_d     = div_wrap ? digit_idx_t'(idx_q + 2'd1) : idx_q;
        sel_bcd   = '0;
        sel_blank = 1'b1;
        sel_minus = 1'b0;

        unique case (idx_d)
            2'd0: begin
                sel_bcd   = ones_q;
                sel_blank = 1'b0;
            end
            2'd1: begin
                sel_bcd   = tens_q;
                sel_blank = (hund_q == 4'd0) && (tens_q == 4'd0);
            end
            2'd2: begin
                sel_bcd   = hund_q;
                sel_blank = (hund_q == 4'd0);
            end
            2'd3: begin
                sel_bcd   = '0;
                sel_blank = !sign_q;
                sel_minus = sign_q;
            end
            default: begin
                sel_bcd   = '0;
                sel_blank = 1'b1;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .blank_i (sel_blank),
        .minus_i (sel_minus),
        .bcd_i   (sel_bcd),
        .seg_o   (dec_seg)
    );

    // an and seg change together, only when the scan advances
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (div_wrap) begin
            an_d  = 4'b0001 << idx_d;
            seg_d = dec_seg;
        end
    end

    // Scan registers; reset shows the ones digit as "0"
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= 4'b0001;
            seg_q <= SEG_0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_out_display.sv
// Directed self-checking bench for out_display with SCAN_DIV=2.
// Covers reset scan, conversion latency, blanking, reload and mid-CONV clear;
// the signed cases are built when SIGNED_DISPLAY_EN is defined.
module tb_out_display;

    logic       clk;
    logic       clr_n;
    logic       out_load;
    logic [7:0] out_data;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;

    int checks = 0;
    int errors = 0;

    out_display #(.SCAN_DIV(2)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .out_load (out_load),
        .out_data (out_data),
        .busy     (busy),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse out_load for one edge; returns at the negedge after that edge
    task automatic load_byte(input logic [7:0] v);
        @(negedge clk);
        out_data = v;
        out_load = 1'b1;
        @(negedge clk);
        out_load = 1'b0;
    endtask

    // Count consecutive negedges with busy high (bounded)
    task automatic measure_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Wait (bounded) until the given digit is enabled, then compare its segments
    task automatic check_digit(input int idx, input logic [6:0] exp, input string tag);
        logic [3:0] want;
        int t;
        want = 4'(1 << idx);
        t = 0;
        while (an !== want && t < 32) begin
            @(negedge clk);
            t++;
        end
        checks++;
        assert (an === want && seg === exp)
        else begin
            errors++;
            $error("FAIL %s: observed an=%b seg=%h expected an=%b seg=%h", tag, an, seg, want, exp);
        end
    endtask

    // Let the scan pass over every digit after an update, then read all four
    task automatic check_display(input logic [6:0] d3, input logic [6:0] d2,
                                 input logic [6:0] d1, input logic [6:0] d0,
                                 input string tag);
        repeat (10) @(negedge clk);
        check_digit(0, d0, {tag, "_ones"});
        check_digit(1, d1, {tag, "_tens"});
        check_digit(2, d2, {tag, "_hund"});
        check_digit(3, d3, {tag, "_d3"});
    endtask

    int n;
    logic b0, b1, b2;

    initial begin
        clr_n    = 1'b0;
        out_load = 1'b0;
        out_data = 8'h00;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_an",   32'(an),   32'h1);
        check("rst_seg",  32'(seg),  32'h3F);
        for (int k = 1; k < 4; k++) begin
            repeat (2) @(negedge clk);
            check($sformatf("rst_scan_an%0d", k),  32'(an),  32'(1 << k));
            check($sformatf("rst_scan_seg%0d", k), 32'(seg), 32'h00);
        end

`ifndef SIGNED_DISPLAY_EN
        // 255: busy exactly 8 cycles, then 2 5 5 with digit 3 blank
        load_byte(8'hFF);
        measure_busy(n);
        check("ff_busy_cycles", 32'(n), 32'd8);
        check_display(7'h00, 7'h5B, 7'h6D, 7'h6D, "ff");
`endif

        // 7: tens and hundreds blanked
        load_byte(8'h07);
        measure_busy(n);
        check("07_busy_cycles", 32'(n), 32'd8);
        check_display(7'h00, 7'h00, 7'h00, 7'h07, "07");

        // 100: inner zeros shown
        load_byte(8'h64);
        measure_busy(n);
        check_display(7'h00, 7'h06, 7'h3F, 7'h3F, "64");

        // Reload three cycles after the first load: latest byte wins
        load_byte(8'h10);
        b0 = busy;
        @(negedge clk);
        b1 = busy;
        @(negedge clk);
        b2 = busy;
        out_data = 8'h2A;
        out_load = 1'b1;
        @(negedge clk);
        out_load = 1'b0;
        measure_busy(n);
        check("reload_busy_before", 32'({b0, b1, b2}), 32'h7);
        check("reload_busy_after",  32'(n), 32'd8);
        check_display(7'h00, 7'h00, 7'h66, 7'h5B, "2a");

`ifdef SIGNED_DISPLAY_EN
        load_byte(8'hF6);
        measure_busy(n);
        check("f6_busy_cycles", 32'(n), 32'd8);
        check_display(7'h40, 7'h00, 7'h06, 7'h3F, "f6");

        load_byte(8'h80);
        measure_busy(n);
        check_display(7'h40, 7'h06, 7'h5B, 7'h7F, "80");

        load_byte(8'h7F);
        measure_busy(n);
        check_display(7'h00, 7'h06, 7'h5B, 7'h07, "7f");
`endif

        // Clear on the 4th CONV edge drops the conversion
        load_byte(8'hC8);
        repeat (3) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_an",   32'(an),   32'h1);
        check("clr_seg",  32'(seg),  32'h3F);
        check_display(7'h00, 7'h00, 7'h00, 7'h3F, "clr");

        // Normal conversion after the clear
        load_byte(8'h05);
        measure_busy(n);
        check("05_busy_cycles", 32'(n), 32'd8);
        check_display(7'h00, 7'h00, 7'h00, 7'h6D, "05");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
